// File: rtl/bus_pkg.sv
// Shared definitions for the CPU-bus memory responder: FSM encoding and bus widths.
package bus_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StAck
  } bus_state_t;

  localparam int unsigned DataWidth = 32;
  localparam int unsigned BeWidth   = 4;
  localparam int unsigned LaneWidth = 8;
  localparam int unsigned CntWidth  = 4;

  // Boot address; upper bits alias away, so it lands on word 0 at the default depth.
  localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;

endpackage

// File: rtl/byte_lane_ram.sv
// Word-organised RAM with per-byte-lane write enables and one registered read port.
module byte_lane_ram
  import bus_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BeWidth-1:0]   we,
  input  logic [AW-1:0]        waddr,
  input  logic [DataWidth-1:0] wdata,
  input  logic                 re,
  input  logic [AW-1:0]        raddr,
  output logic [DataWidth-1:0] rdata
);

  logic [DataWidth-1:0] mem [DEPTH_WORDS];

  // Storage is deliberately not touched by reset so preloaded code survives it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(BeWidth); i++) begin
      if (we[i]) begin
        mem[waddr][LaneWidth*i +: LaneWidth] <= wdata[LaneWidth*i +: LaneWidth];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/avalon_mem_responder.sv
// Avalon-MM slave serving CPU bus transfers from internal RAM with a fixed number of
// stall cycles, plus a side preload port.
module avalon_mem_responder
  import bus_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_CYCLES = 2,
  localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          address,
  input  logic                 read,
  input  logic                 write,
  input  logic [BeWidth-1:0]   byteenable,
  input  logic [DataWidth-1:0] writedata,
  output logic                 waitrequest,
  output logic [DataWidth-1:0] readdata,
  input  logic                 load_en,
  input  logic [AW+1:0]        load_addr,
  input  logic [DataWidth-1:0] load_data,
  output logic                 err
);

  localparam logic [CntWidth-1:0] WaitCnt = CntWidth'(WAIT_CYCLES);

  bus_state_t          state_q, state_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                err_q, err_d;
  logic                req, latch, bus_we;
  logic [BeWidth-1:0]  ram_we;
  logic [AW-1:0]       ram_waddr;
  logic [DataWidth-1:0] ram_wdata;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{address[31:AW+2], load_addr[1:0]};

  assign req = read | write;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    latch       = 1'b0;
    waitrequest = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          waitrequest = 1'b1;
          if ((read && write) || (address[1:0] != 2'b00)) begin
            err_d = 1'b1;
          end
          if (WaitCnt == '0) begin
            state_d = StAck;
            latch   = 1'b1;
          end else begin
            cnt_d   = WaitCnt;
            state_d = StBusy;
          end
        end
      end
      StBusy: begin
        waitrequest = 1'b1;
        if (!req) begin
          // Master dropped its request mid-stall: abandon the transfer.
          state_d = StIdle;
          cnt_d   = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CntWidth'(1)) begin
            state_d = StAck;
            latch   = 1'b1;
          end
        end
      end
      StAck: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    if (reset) begin
      waitrequest = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign err = err_q;

  // Preload owns the single write port whenever it is active; the bus write is dropped.
  assign bus_we    = (state_q == StAck) && write && !reset;
  assign ram_we    = load_en ? {BeWidth{1'b1}} : (bus_we ? byteenable : '0);
  assign ram_waddr = load_en ? load_addr[AW+1:2] : address[AW+1:2];
  assign ram_wdata = load_en ? load_data : writedata;

  byte_lane_ram #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_ram (
    .clk  (clk),
    .reset(reset),
    .we   (ram_we),
    .waddr(ram_waddr),
    .wdata(ram_wdata),
    .re   (latch && read && !reset),
    .raddr(address[AW+1:2]),
    .rdata(readdata)
  );

endmodule

// File: tb/tb_avalon_mem_responder.sv
// Directed bench for avalon_mem_responder: two instances (2 and 0 wait states) share
// data/preload/reset inputs; read results are checked through a scoreboard queue.
module tb_avalon_mem_responder;
  import bus_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address, writedata, load_data;
  logic [3:0]  byteenable;
  logic        load_en;
  logic [9:0]  load_addr;
  logic        rd2, wr2, rd0, wr0;
  logic        wait2, wait0, err2, err0;
  logic [31:0] rdata2, rdata0;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  avalon_mem_responder #(
    .DEPTH_WORDS(256),
    .WAIT_CYCLES(2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .read       (rd2),
    .write      (wr2),
    .byteenable (byteenable),
    .writedata  (writedata),
    .waitrequest(wait2),
    .readdata   (rdata2),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .err        (err2)
  );

  avalon_mem_responder #(
    .DEPTH_WORDS(256),
    .WAIT_CYCLES(0)
  ) dut0 (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .read       (rd0),
    .write      (wr0),
    .byteenable (byteenable),
    .writedata  (writedata),
    .waitrequest(wait0),
    .readdata   (rdata0),
    .load_en    (load_en),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .err        (err0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // Starts at a falling edge; returns at the falling edge after the ACK cycle.
  task automatic xfer(input bit z, input bit rd, input bit wr, input logic [31:0] addr,
                      input logic [3:0] be, input logic [31:0] wd, input int exp_stall,
                      input bit collide, input logic [31:0] cdata);
    int stall = 0;
    logic [31:0] exp;
    address = addr; byteenable = be; writedata = wd;
    if (z) begin rd0 = rd; wr0 = wr; end
    else begin rd2 = rd; wr2 = wr; end
    #1;
    while ((z ? wait0 : wait2) && stall < 40) begin
      stall++;
      @(negedge clk);
      #1;
    end
    check(z ? "stall_w0" : "stall_w2", 32'(stall), 32'(exp_stall));
    if (collide) begin
      load_en = 1'b1; load_addr = addr[9:0]; load_data = cdata;
    end
    if (rd) begin
      if (exp_q.size() != 0) begin
        exp = exp_q.pop_front();
        check(z ? "readdata_w0" : "readdata_w2", z ? rdata0 : rdata2, exp);
      end else begin
        total++; bad++;
        $error("FAIL scoreboard_empty observed=read expected=none");
      end
    end
    @(negedge clk);
    rd0 = 1'b0; wr0 = 1'b0; rd2 = 1'b0; wr2 = 1'b0; load_en = 1'b0;
  endtask

  initial begin
    reset = 1'b1; address = '0; writedata = '0; byteenable = '0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    rd2 = 1'b1; wr2 = 1'b0; rd0 = 1'b0; wr0 = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_wait", {31'b0, wait2}, 32'd0);
    check("reset_rdata", rdata2, 32'h0);
    check("reset_err", {31'b0, err2}, 32'd0);
    rd2 = 1'b0;

    preload(10'h000, 32'h2403F00F);
    preload(10'h004, 32'h00031C00);
    preload(10'h014, 32'h11223344);
    preload(10'h01C, 32'hCAFEF00D);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Preload and read, with upper address bits aliasing away.
    exp_q.push_back(32'h00031C00);
    xfer(0, 1, 0, 32'hBFC00004, 4'hF, 32'h0, 3, 0, 32'h0);
    check("err_clean", {31'b0, err2}, 32'd0);
    exp_q.push_back(32'h2403F00F);
    xfer(0, 1, 0, RESET_VECTOR, 4'hF, 32'h0, 3, 0, 32'h0);

    // Byte-enabled write over 0x11223344.
    xfer(0, 0, 1, 32'h14, 4'b0101, 32'hAABBCCDD, 3, 0, 32'h0);
    check("rdata_hold", rdata2, 32'h2403F00F);
    exp_q.push_back(32'h11BB33DD);
    xfer(0, 1, 0, 32'h14, 4'hF, 32'h0, 3, 0, 32'h0);

    // Zero wait states: read, write, read back-to-back.
    exp_q.push_back(32'h2403F00F);
    xfer(1, 1, 0, 32'h0, 4'hF, 32'h0, 1, 0, 32'h0);
    xfer(1, 0, 1, 32'h8, 4'hF, 32'h12345678, 1, 0, 32'h0);
    check("rdata_hold_w0", rdata0, 32'h2403F00F);
    exp_q.push_back(32'h12345678);
    xfer(1, 1, 0, 32'h8, 4'hF, 32'h0, 1, 0, 32'h0);
    check("err_w0", {31'b0, err0}, 32'd0);

    // Read and write together: old word returned, write lands, err sticks.
    exp_q.push_back(32'h11BB33DD);
    xfer(0, 1, 1, 32'h14, 4'hF, 32'h0F0F0F0F, 3, 0, 32'h0);
    check("err_rdwr", {31'b0, err2}, 32'd1);
    exp_q.push_back(32'h0F0F0F0F);
    xfer(0, 1, 0, 32'h14, 4'hF, 32'h0, 3, 0, 32'h0);
    check("err_sticky", {31'b0, err2}, 32'd1);

    // Reset during BUSY of a write to a preloaded word.
    address = 32'h1C; writedata = 32'h0; byteenable = 4'hF; wr2 = 1'b1;
    @(negedge clk);
    #1;
    check("busy_wait", {31'b0, wait2}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; wr2 = 1'b0;
    #1;
    check("post_reset_wait", {31'b0, wait2}, 32'd0);
    check("post_reset_rdata", rdata2, 32'h0);
    check("post_reset_err", {31'b0, err2}, 32'd0);
    @(negedge clk);
    exp_q.push_back(32'hCAFEF00D);
    xfer(0, 1, 0, 32'h1C, 4'hF, 32'h0, 3, 0, 32'h0);

    // Misaligned access proceeds on the word but flags err.
    exp_q.push_back(32'h0F0F0F0F);
    xfer(0, 1, 0, 32'h16, 4'hF, 32'h0, 3, 0, 32'h0);
    check("err_misaligned", {31'b0, err2}, 32'd1);

    // Preload colliding with the ACK-cycle bus write wins.
    xfer(0, 0, 1, 32'h24, 4'hF, 32'hDEADBEEF, 3, 1, 32'h5A5A5A5A);
    exp_q.push_back(32'h5A5A5A5A);
    xfer(0, 1, 0, 32'h24, 4'hF, 32'h0, 3, 0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
